// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage ALU with a start/done handshake, an iterative
// radix-2 shift-add multiplier and a 2*WIDTH HI/LO accumulator (madd/msub).
// Build option: define MUL_SIGNED_EN to make mul/madd/msub two's complement.
// In that build, the multiplier works on operand magnitudes and the product is
// negated in FIN when the operand signs differ. Otherwise all three are
// unsigned and the negation logic is not built.
//
// Handshake: Start (with ALUControl/A/B) is accepted only on a rising edge
// where Ready=1. Ready and Busy are complementary, and both come from the
// state register. Done is a registered one-cycle pulse. It is high in the
// cycle where ALUResult/Zero (and Hi/Lo for madd/msub) first show the new
// values. A Start that arrives while Ready=0 is dropped without any effect.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [3:0]           ALUControl,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 HiLoWe,
    input  logic [2*WIDTH-1:0]   HiLoIn,
    output logic                 Ready,
    output logic                 Busy,
    output logic                 Done,
    output logic [WIDTH-1:0]     ALUResult,
    output logic                 Zero,
    output logic [WIDTH-1:0]     Hi,
    output logic [WIDTH-1:0]     Lo,
    output logic [1:0]           dbg_state
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_ROTR = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SEH  = 4'b1011;
    localparam logic [3:0] OP_MADD = 4'b1100;
    localparam logic [3:0] OP_MSUB = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b1110;
    localparam logic [3:0] OP_SEB  = 4'b1111;

    localparam logic [SHW-1:0] LAST_BIT = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   hilo_q, hilo_d;
    logic [3:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [SHW-1:0]       count_q, count_d;
`ifdef MUL_SIGNED_EN
    logic                 neg_q, neg_d;
`endif

    logic [SHW-1:0]       shamt;
    logic [WIDTH-1:0]     alu_out;
    logic                 is_mul_op;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   prod_fin;

    assign shamt     = B[SHW-1:0];
    assign is_mul_op = (ALUControl == OP_MUL) || (ALUControl == OP_MADD) ||
                       (ALUControl == OP_MSUB);

    // Single-cycle operation results, computed directly from the live inputs.
    always_comb begin
        alu_out = '0;
        case (ALUControl)
            OP_ADD:  alu_out = A + B;
            OP_SUB:  alu_out = A - B;
            OP_AND:  alu_out = A & B;
            OP_OR:   alu_out = A | B;
            OP_XOR:  alu_out = A ^ B;
            OP_NOR:  alu_out = ~(A | B);
            OP_SLL:  alu_out = A << shamt;
            OP_SRL:  alu_out = A >> shamt;
            OP_ROTR: alu_out = WIDTH'({A, A} >> shamt);
            OP_SRA:  alu_out = $signed(A) >>> shamt;
            OP_SEH:  alu_out = {{(WIDTH-16){A[15]}}, A[15:0]};
            OP_SEB:  alu_out = {{(WIDTH-8){A[7]}}, A[7:0]};
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: alu_out = '0;
        endcase
    end

    // Multiplier operand preparation. The signed build multiplies the
    // magnitudes. The most negative value maps to itself, and that is the
    // correct unsigned magnitude.
    always_comb begin
`ifdef MUL_SIGNED_EN
        a_mag = A[WIDTH-1] ? (-A) : A;
        b_mag = B[WIDTH-1] ? (-B) : B;
`else
        a_mag = A;
        b_mag = B;
`endif
    end

    // Final product as a signed quantity, used only in FIN.
    always_comb begin
        prod_fin = prod_q;
`ifdef MUL_SIGNED_EN
        if (neg_q) begin
            prod_fin = -prod_q;
        end
`endif
    end

    // Next-state and datapath control for the IDLE/MUL/FIN sequence.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        done_d   = 1'b0;
        hilo_d   = hilo_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        count_d  = count_q;
`ifdef MUL_SIGNED_EN
        neg_d    = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (is_mul_op) begin
                        op_d     = ALUControl;
                        mcand_d  = {{WIDTH{1'b0}}, a_mag};
                        mplier_d = b_mag;
                        prod_d   = '0;
                        count_d  = '0;
`ifdef MUL_SIGNED_EN
                        neg_d    = A[WIDTH-1] ^ B[WIDTH-1];
`endif
                        state_d  = S_MUL;
                    end else begin
                        result_d = alu_out;
                        done_d   = 1'b1;
                    end
                end else if (HiLoWe) begin
                    // A load takes effect only when no Start is presented.
                    hilo_d = HiLoIn;
                end
            end
            S_MUL: begin
                // One multiplier bit per cycle, LSB first.
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_ONE;
                if (count_q == LAST_BIT) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                case (op_q)
                    OP_MADD: hilo_d = hilo_q + prod_fin;
                    OP_MSUB: hilo_d = hilo_q - prod_fin;
                    default: hilo_d = hilo_q;
                endcase
                result_d = (op_q == OP_MUL) ? prod_fin[WIDTH-1:0] : hilo_d[WIDTH-1:0];
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Zero always follows the result register and never follows HI.
        zero_d = (result_d == '0);
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers. An aborted operation leaves no trace.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            hilo_q   <= '0;
            op_q     <= OP_ADD;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            count_q  <= '0;
`ifdef MUL_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            hilo_q   <= hilo_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
`ifdef MUL_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign Ready     = (state_q == S_IDLE);
    assign Busy      = (state_q != S_IDLE);
    assign Done      = done_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Hi        = hilo_q[2*WIDTH-1:WIDTH];
    assign Lo        = hilo_q[WIDTH-1:0];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: randomized and directed checks of alu_multicycle
// (WIDTH=32) against a behavioural model. The model follows MUL_SIGNED_EN in
// the same way as the design.
module tb_alu_multicycle;
  localparam int W = 32;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [3:0]    ALUControl = '0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          HiLoWe = 1'b0;
  logic [2*W-1:0] HiLoIn = '0;
  logic          Ready, Busy, Done, Zero;
  logic [W-1:0]  ALUResult, Hi, Lo;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0]   exp_q[$];
  logic [2*W-1:0] m_hilo = '0;

  alu_multicycle #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ALUControl(ALUControl),
    .A(A), .B(B), .HiLoWe(HiLoWe), .HiLoIn(HiLoIn),
    .Ready(Ready), .Busy(Busy), .Done(Done), .ALUResult(ALUResult),
    .Zero(Zero), .Hi(Hi), .Lo(Lo), .dbg_state(dbg_state)
  );

  // clock
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mul(input logic [3:0] op);
    return (op == 4'b0010) || (op == 4'b1100) || (op == 4'b1101);
  endfunction

  // Reference model: plain arithmetic, full 64-bit products.
  task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]   r;
    logic [2*W-1:0] p;
    int s;
    s = int'(b[4:0]);
`ifdef MUL_SIGNED_EN
    p = longint'($signed(a)) * longint'($signed(b));
`else
    p = longint'({32'b0, a}) * longint'({32'b0, b});
`endif
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = p[W-1:0];
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  r = a ^ b;
      4'd6:  r = ~(a | b);
      4'd7:  r = a << s;
      4'd8:  r = a >> s;
      4'd9:  r = (s == 0) ? a : ((a >> s) | (a << (W - s)));
      4'd10: r = $signed(a) >>> s;
      4'd11: r = {{16{a[15]}}, a[15:0]};
      4'd12: begin m_hilo = m_hilo + p; r = m_hilo[W-1:0]; end
      4'd13: begin m_hilo = m_hilo - p; r = m_hilo[W-1:0]; end
      4'd14: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = {{24{a[7]}}, a[7:0]};
    endcase
    exp_q.push_back(r);
  endtask

  // Driver: called and returns at posedge+1. Launches one op, optionally
  // hammers Start/HiLoWe while busy, and waits (bounded) for Done.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    int k, busy_cnt, exp_lat;
    bit got;
    logic [W-1:0] exp_r;
    model_op(op, a, b);
    exp_lat = is_mul(op) ? W + 2 : 1;
    Start = 1'b1; ALUControl = op; A = a; B = b;
    k = 0; busy_cnt = 0; got = 0;
    while (!got && k < exp_lat + 4) begin
      @(posedge Clk); #1;
      k++;
      if (k == 1) begin Start = 1'b0; HiLoWe = 1'b0; end
      if (poke && k == 3) begin
        Start = 1'b1; ALUControl = 4'd0; A = ~a; B = b + 32'd7;
        HiLoWe = 1'b1; HiLoIn = {$urandom, $urandom};
      end
      if (poke && k == 4) begin Start = 1'b0; HiLoWe = 1'b0; end
      if (Done) got = 1;
      else if (Busy) busy_cnt++;
    end
    exp_r = exp_q.pop_front();
    check("done_seen", 64'(got), 64'd1);
    check("latency", 64'(k), 64'(exp_lat));
    check("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
    check("result", 64'(ALUResult), 64'(exp_r));
    check("zero", 64'(Zero), 64'(exp_r == '0));
    check("hilo", {Hi, Lo}, m_hilo);
    check("ready_on_done", 64'(Ready), 64'd1);
  endtask

  task automatic hilo_load(input logic [2*W-1:0] v);
    HiLoWe = 1'b1; HiLoIn = v;
    @(posedge Clk); #1;
    HiLoWe = 1'b0;
    m_hilo = v;
    check("hilo_load", {Hi, Lo}, m_hilo);
    check("hilo_load_no_done", 64'(Done), 64'd0);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'(($urandom_range(0, 63)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int k;
    bit seen;
    // reset
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    check("rst_ready", 64'(Ready), 64'd1);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_result", 64'(ALUResult), 64'd0);
    check("rst_zero", 64'(Zero), 64'd1);
    check("rst_hilo", {Hi, Lo}, 64'd0);

    // directed single-cycle ops, back to back
    run_op(4'd0,  32'h7FFF_FFFF, 32'h1, 0);
    run_op(4'd1,  32'd5, 32'd5, 0);
    run_op(4'd9,  32'h8000_0001, 32'd36, 0);
    run_op(4'd14, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd15, 32'h0000_0080, 32'd0, 0);
    run_op(4'd11, 32'h1234_8001, 32'd0, 0);
    run_op(4'd10, 32'h8000_0000, 32'd31, 0);

    // mul with Start/HiLoWe poked while busy
    hilo_load(64'hDEAD_BEEF_0BAD_F00D);
    run_op(4'd2, 32'h0001_0000, 32'h0001_0000, 1);
    @(posedge Clk); #1;
    check("done_one_cycle", 64'(Done), 64'd0);

    hilo_load(64'h1);
    run_op(4'd12, 32'hFFFF_FFFF, 32'd2, 1);
    hilo_load(64'h0);
    run_op(4'd13, 32'd3, 32'd4, 0);

    // Start and HiLoWe together: Start wins
    HiLoWe = 1'b1; HiLoIn = 64'h5555_5555_AAAA_AAAA;
    run_op(4'd4, 32'h00F0, 32'h0F00, 0);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) hilo_load({$urandom, $urandom});
      run_op(op, rand_operand(), rand_operand(), bit'($urandom_range(0, 1)));
    end

    // reset in the middle of a mul
    hilo_load(64'h0123_4567_89AB_CDEF);
    Start = 1'b1; ALUControl = 4'd2; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    for (k = 1; k <= 10; k++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
    end
    check("busy_before_abort", 64'(Busy), 64'd1);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    m_hilo = '0;
    check("abort_ready", 64'(Ready), 64'd1);
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_result", 64'(ALUResult), 64'd0);
    check("abort_zero", 64'(Zero), 64'd1);
    check("abort_hilo", {Hi, Lo}, m_hilo);
    seen = 0;
    for (int j = 0; j < W + 4; j++) begin
      if (Done) seen = 1;
      @(posedge Clk); #1;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
